seg_display_scan: RTL and testbench
===================================

Name: seg_display_scan

Overview:
Time-multiplexed 7-segment driver for the Artix-7 board's 8-digit common-anode display. It consumes the six BCD time digits (hrs/min/sec tens and ones) produced by the time-entry/clock stage and scans them onto the shared cathode bus. The digit pair currently being edited (selected by the same 2-bit mode used for time entry) blinks. Active-low anodes and segments go straight to the board pins.

Parameters:
DIGIT_PERIOD, 100000, clk cycles each digit stays lit (1 ms at 100 MHz); must be >= 1
BLINK_HALF, 50000000, clk cycles per blink half-period (0.5 s at 100 MHz); must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
mode  input  2  edit select: 0 none, 1 seconds, 2 minutes, 3 hours
hrstens  input  4  BCD hours tens
hrsones  input  4  BCD hours ones
mintens  input  4  BCD minutes tens
minones  input  4  BCD minutes ones
sectens  input  4  BCD seconds tens
secones  input  4  BCD seconds ones
an  output  8  anode enables, active low; an[0] is the rightmost digit
seg  output  7  cathodes {g,f,e,d,c,b,a}, active low
dp  output  1  decimal point, active low

Behaviour:
- Reset, sampled on the clk rising edge:
  - Outputs: an=8'hFF, seg=7'h7F, dp=1.
  - State: div_cnt=0, idx=0, blink_cnt=0, blink_vis=1, mode_q=mode.
- Scan divider: div_cnt counts 0..DIGIT_PERIOD-1 and wraps to 0. When div_cnt reaches DIGIT_PERIOD-1, idx advances on the next edge: 0->1->...->5->0.
- Slot map:
  - idx0 = secones, idx1 = sectens
  - idx2 = minones, idx3 = mintens
  - idx4 = hrsones, idx5 = hrstens
- Anode map: an[idx] is driven low; all other bits, including an[7:6], stay high.
- Output registers: an/seg/dp load every cycle from the current idx and current inputs.
  - Latency: an input change appears on seg one cycle later, provided its slot is active.
  - On an idx change, the anode and cathode values change on the same edge. No cycle pairs the old anode with new cathodes.
- Decode:
  - 0-9 use standard patterns, e.g. 0=7'b1000000, 1=7'b1111001, 8=7'b0000000.
  - Any value 10-15 shows a dash, 7'b0111111.
  - Leading zeros are displayed.
- Decimal point: dp=0 when idx is 2 or 4 (hh.mm.ss separators); otherwise dp=1.
- Blink counter: blink_cnt counts 0..BLINK_HALF-1 and wraps. On wrap, blink_vis toggles.
- Blink restart: mode_q is registered each cycle. If mode != mode_q, then on that edge blink_cnt=0 and blink_vis=1, so a newly selected field is shown immediately. A mode change on the same cycle as a blink wrap: the restart wins.
- Blanking: when blink_vis=0 and mode != 0, the slots in the selected pair drive an high for their whole period:
  - mode 1 -> idx 0,1
  - mode 2 -> idx 2,3
  - mode 3 -> idx 4,5
  The scan timing (div_cnt, idx) is unaffected. mode=0 never blanks.
- Reset mid-scan returns to the reset state on the next edge. No partial slot carries over.
- Widths: div_cnt is $clog2(DIGIT_PERIOD+1) bits, blink_cnt is $clog2(BLINK_HALF+1) bits, idx is 3 bits. Values 6/7 of idx are unreachable; if reached, idx forces to 0 on the next edge.

Decomposition:
- Shared package seg_pkg holds:
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (7'h7F)
  - the mode encoding constants MODE_NONE/SEC/MIN/HRS, shared with the time-entry stage
- One combinational sub-module, bcd_to_seg (4-bit in, 7-bit active-low out). It is instantiated once on the muxed digit.

Test Plan:
1. Reset: DIGIT_PERIOD=4, BLINK_HALF=32, assert reset 3 cycles with inputs 12:34:56 -> an=FF, seg=7F, dp=1 during reset; first cycle after release an=FE, seg=SEG_6.
2. Full scan, inputs 12:34:56, mode=0 -> an steps FE,FD,FB,F7,EF,DF every 4 cycles with seg 6,5,4,3,2,1; dp=0 only with FB and EF; an[7:6] never low; the sequence repeats every 24 cycles.
3. Blink, mode=2 held -> cycles 0-31 show all digits; cycles 32-63 have an[2], an[3] high during idx 2/3 slots while the other slots display normally; cycles 64+ show all digits again.
4. Blink restart: switch mode from 2 to 3 at cycle 40 (blink_vis=0) -> minutes visible on the next slot; hours blank only from cycle 41+32.
5. Invalid BCD, secones=4'hC -> idx0 slot shows seg=7'b0111111; other digits unaffected.
6. Reset mid-scan: assert reset during the idx=3 slot -> next edge an=FF; after release, the scan restarts at idx0 with a full 4-cycle slot.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display path: active-low cathode
// patterns ({g,f,e,d,c,b,a}) and the edit-mode encoding used by time entry.
package seg_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [7:0] AN_OFF   = 8'hFF;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_SEC  = 2'd1,
    MODE_MIN  = 2'd2,
    MODE_HRS  = 2'd3
  } mode_e;

  // True when scan slot idx belongs to the digit pair selected by mode.
  function automatic logic slot_selected(input logic [2:0] idx, input logic [1:0] mode);
    logic sel;
    sel = 1'b0;
    case (mode)
      MODE_SEC: sel = (idx == 3'd0) || (idx == 3'd1);
      MODE_MIN: sel = (idx == 3'd2) || (idx == 3'd3);
      MODE_HRS: sel = (idx == 3'd4) || (idx == 3'd5);
      default:  sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup from digit value to cathode pattern.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed driver for the 8-digit common-anode display. Scans the six
// time digits right to left, marks hh.mm.ss with decimal points and blinks the
// digit pair currently selected for editing.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int DIGIT_PERIOD = 100000,
  parameter int BLINK_HALF   = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [3:0] hrstens,
  input  logic [3:0] hrsones,
  input  logic [3:0] mintens,
  input  logic [3:0] minones,
  input  logic [3:0] sectens,
  input  logic [3:0] secones,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV_W = $clog2(DIGIT_PERIOD + 1);
  localparam int BLK_W = $clog2(BLINK_HALF + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIGIT_PERIOD - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_vis_q, blink_vis_d;
  logic [1:0]       mode_q;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic [3:0]       digit;
  logic [6:0]       digit_seg;
  logic             mode_changed;

  assign mode_changed = (mode != mode_q);

  bcd_to_seg u_bcd_to_seg (
    .bcd (digit),
    .seg (digit_seg)
  );

  // Scan divider and slot index; an out-of-range index recovers to slot 0.
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    idx_d     = idx_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      idx_d     = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
    if (idx_q > 3'd5) begin
      idx_d = 3'd0;
    end
  end

  // Blink timebase; a mode change restarts it visible so the new field shows at once.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLK_W'(1);
    blink_vis_d = blink_vis_q;
    if (mode_changed) begin
      blink_cnt_d = '0;
      blink_vis_d = 1'b1;
    end else if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d = '0;
      blink_vis_d = ~blink_vis_q;
    end
  end

  // Next display values for the current slot, with the edited pair blanked in its off phase.
  always_comb begin
    digit = 4'd0;
    case (idx_q)
      3'd0:    digit = secones;
      3'd1:    digit = sectens;
      3'd2:    digit = minones;
      3'd3:    digit = mintens;
      3'd4:    digit = hrsones;
      3'd5:    digit = hrstens;
      default: digit = 4'd0;
    endcase

    if (idx_q <= 3'd5) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = digit_seg;
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end

    if (!(blink_vis_q || mode_changed) && slot_selected(idx_q, mode)) begin
      an_d = AN_OFF;
    end

    dp_d = !((idx_q == 3'd2) || (idx_q == 3'd4));
  end

  // All state and the pin registers update together so anode and cathodes never disagree.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      idx_q       <= 3'd0;
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
      mode_q      <= mode;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_vis_q <= blink_vis_d;
      mode_q      <= mode;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with a 4-cycle digit slot and a
// 32-cycle blink half-period. Cycle c is the output seen after the (c+1)th
// clock edge following reset release; its scan slot is (c/4)%6.
module tb_seg_display_scan;

  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S6   = 7'b0000010;
  localparam logic [6:0] SDSH = 7'b0111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [3:0] hrstens, hrsones, mintens, minones, sectens, secones;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] anTab  [6] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};
  logic       dpTab  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [6:0] segExp [6];

  seg_display_scan #(
    .DIGIT_PERIOD (4),
    .BLINK_HALF   (32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .hrstens (hrstens),
    .hrsones (hrsones),
    .mintens (mintens),
    .minones (minones),
    .sectens (sectens),
    .secones (secones),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [3:0] ht, input logic [3:0] ho,
                               input logic [3:0] mt, input logic [3:0] mo,
                               input logic [3:0] st, input logic [3:0] so);
    mode    = m;
    hrstens = ht;
    hrsones = ho;
    mintens = mt;
    minones = mo;
    sectens = st;
    secones = so;
  endtask

  task automatic holdReset(input string name, input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s rst%0d an", name, i), an, 8'hFF);
      checkOutput($sformatf("%s rst%0d seg", name, i), {1'b0, seg}, 8'h7F);
      checkOutput($sformatf("%s rst%0d dp", name, i), {7'b0, dp}, 8'h01);
    end
    reset = 1'b0;
  endtask

  task automatic checkCycle(input string name, input int c, input logic blanked);
    int slot;
    slot = (c / 4) % 6;
    @(posedge clk);
    #1;
    if (blanked) begin
      checkOutput($sformatf("%s c%0d an(blank)", name, c), an, 8'hFF);
    end else begin
      checkOutput($sformatf("%s c%0d an", name, c), an, anTab[slot]);
      checkOutput($sformatf("%s c%0d seg", name, c), {1'b0, seg}, {1'b0, segExp[slot]});
      checkOutput($sformatf("%s c%0d dp", name, c), {7'b0, dp}, {7'b0, dpTab[slot]});
    end
  endtask

  initial begin
    int slot;
    reset = 1'b1;
    applyStimulus(2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    segExp = '{S6, S5, S4, S3, S2, S1};

    // Reset then two full scans of 12:34:56 with no editing.
    holdReset("scan", 3);
    for (int c = 0; c < 48; c++) checkCycle("scan", c, 1'b0);

    // Minutes blink: blanked only in the off phase, cycles 32..63.
    applyStimulus(2'd2, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    holdReset("blink", 2);
    for (int c = 0; c < 96; c++) begin
      slot = (c / 4) % 6;
      checkCycle("blink", c, (c >= 32) && (c < 64) && (slot == 2 || slot == 3));
    end

    // Mode 2 -> 3 at cycle 40 restarts the blink; hours next go dark at cycle 73.
    applyStimulus(2'd2, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    holdReset("restart", 2);
    for (int c = 0; c < 104; c++) begin
      slot = (c / 4) % 6;
      if (c == 40) mode = 2'd3;
      checkCycle("restart", c,
                 ((c >= 32) && (c < 40) && (slot == 2 || slot == 3)) ||
                 ((c >= 73) && (slot == 4 || slot == 5)));
    end

    // Non-decimal seconds-ones digit shows a dash; the rest are unchanged.
    applyStimulus(2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'hC);
    segExp[0] = SDSH;
    holdReset("badbcd", 2);
    for (int c = 0; c < 24; c++) checkCycle("badbcd", c, 1'b0);

    // Reset during the idx3 slot, then the scan restarts with a full slot 0.
    applyStimulus(2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    segExp[0] = S6;
    holdReset("midrst", 2);
    for (int c = 0; c < 14; c++) checkCycle("midrst", c, 1'b0);
    holdReset("midrst hit", 1);
    for (int c = 0; c < 8; c++) checkCycle("midrst after", c, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
